mem_max_scanner: RTL
====================

Name: mem_max_scanner

Overview:
- Bus initiator that drives the data-memory port (memWrite, addr, writeData, readData), the other end of the data memory's responder interface.
- On start, it reads COUNT consecutive words from a base address and tracks the largest value and its index.
- When the scan finishes, it writes the largest value back to a destination address and pulses done.
- Sits beside the datapath as a memory-side accelerator; shares the memory port under an external mux selected by busy.

Parameters:
- ADDR_W, 32, width of addr, base and dst addresses (byte addresses).
- CNT_W, 11, width of count and index; allows up to 1024 words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- base_addr  input  ADDR_W  byte address of first word; bits [1:0] ignored (treated as 00).
- dst_addr  input  ADDR_W  byte address for the result write; bits [1:0] ignored.
- count  input  CNT_W  number of words to scan.
- memWrite  output  1  write strobe to data memory.
- addr  output  ADDR_W  word-aligned byte address to data memory.
- writeData  output  32  data to data memory.
- readData  input  32  combinational read data from data memory, valid in the same cycle as addr.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at completion.
- max_val  output  32  largest word found; held until the next accepted start.
- max_idx  output  CNT_W  word offset of the first occurrence of max_val.
- empty  output  1  set when the last scan had count==0.

Behaviour:
- Reset (async, rst_n=0, effective immediately even mid-scan):
  - state=IDLE; memWrite=0, addr=0, writeData=0.
  - busy=0, done=0, max_val=0, max_idx=0, empty=0.
  - Internal index and latched addresses/count cleared.
  - An aborted scan issues no write. memWrite deasserts without waiting for clk.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If start=1 at edge E0: latch base, dst and count.
  - Clear max_val=0, max_idx=0, i=0, empty=0.
  - Go to READ if count!=0; otherwise set empty=1 and go to DONE.
  - busy=1 from E0.
- READ:
  - addr = {base[ADDR_W-1:2],00} + 4*i, with modulo 2^ADDR_W wrap; memWrite=0.
  - At each edge, if i==0 or readData > max_val (strictly greater), load max_val=readData and max_idx=i. Ties keep the earlier index.
  - After processing i==count-1, go to WRITE; otherwise i increments.
  - Exactly count READ cycles.
- WRITE:
  - One cycle with memWrite=1, addr = dst aligned, writeData = max_val.
  - The write commits at the ending edge; go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE; memWrite=0.
  - max_val, max_idx and empty hold until the next accepted start.
- Latency:
  - For count=N>0, done is high in the cycle after edge E0+N+1; total N+2 cycles after acceptance.
  - For count=0, done is high in the cycle after E0+1, with no memory write.
- Address outputs are registered from state/index (no combinational path from start to addr).
- addr and writeData are 0 whenever state is IDLE or DONE.
- start while busy or in DONE is ignored; it is not queued.
- Comparison is unsigned by default.
- dst inside the scanned range is allowed: the write occurs after all reads, so read values are unaffected.

Optional Feature:
- Macro SCAN_SIGNED_CMP_EN.
- When defined: comparison treats words as two's-complement signed, so 0x80000000 is the minimum and 0x7FFFFFFF the maximum.
- When undefined: unsigned comparison only; no signed logic synthesized.
- Ports and timing are identical in both builds.

Test Plan:
- Full scan, unsigned:
  - Stimulus: preload words 0..19 with the team test image (word5=0xFFFFFFFF, all others smaller); start, base=0, dst=0x100, count=20.
  - Response: max_val=0xFFFFFFFF, max_idx=5; memory word 64 = 0xFFFFFFFF; done 22 cycles after acceptance; memWrite high exactly one cycle.
- Tie and alignment:
  - Stimulus: words 2 and 7 = 0x12345678, others 0x1; base=0x3 (treated as 0x0), count=10.
  - Response: max_idx=2; addr sequence 0x0,0x4,...,0x24.
- count=0:
  - Response: done one cycle after the first READ-equivalent cycle (E0+1), empty=1, max_val=0, memWrite never asserted.
- Reset mid-scan:
  - Stimulus: assert rst_n=0 during READ i=4 of a count=20 scan.
  - Response: memWrite=0, busy=0, max_val=0 immediately; dst word unchanged; a new start afterwards behaves normally.
- Start while busy:
  - Stimulus: second start pulse during READ.
  - Response: ignored; single done, single write.
- Signed build (SCAN_SIGNED_CMP_EN):
  - Stimulus: words {0xFFFFFFFF, 0x00000005, 0x80000000}, count=3.
  - Response: max_val=0x5, max_idx=1. Unsigned build: max_val=0xFFFFFFFF, max_idx=0.

Source files
------------

// File: rtl/mem_max_scanner.sv
// Memory-side accelerator: reads COUNT words from base, finds the largest (first index
// on ties) and writes it to dst. Define SCAN_SIGNED_CMP_EN for two's-complement compare.
module mem_max_scanner #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              memWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       writeData,
    input  logic [31:0]       readData,
    output logic              busy,
    output logic              done,
    output logic [31:0]       max_val,
    output logic [CNT_W-1:0]  max_idx,
    output logic              empty
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] base_r, base_n;
    logic [ADDR_W-1:0] dst_r, dst_n;
    logic [ADDR_W-1:0] addr_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [CNT_W-1:0]  idx, idx_n, idx_inc;
    logic [CNT_W-1:0]  max_idx_n;
    logic [31:0]       max_val_n;
    logic [31:0]       write_data_n;
    logic              mem_write_n;
    logic              busy_n;
    logic              done_n;
    logic              empty_n;
    logic              gt;
    logic              take;
    logic              last;

`ifdef SCAN_SIGNED_CMP_EN
    assign gt = $signed(readData) > $signed(max_val);
`else
    assign gt = readData > max_val;
`endif

    assign take    = (idx == '0) || gt;
    assign last    = (idx == cnt_r - CNT_W'(1));
    assign idx_inc = idx + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        base_n       = base_r;
        dst_n        = dst_r;
        cnt_n        = cnt_r;
        idx_n        = idx;
        addr_n       = addr;
        mem_write_n  = 1'b0;
        write_data_n = writeData;
        busy_n       = busy;
        done_n       = 1'b0;
        max_val_n    = max_val;
        max_idx_n    = max_idx;
        empty_n      = empty;

        case (state)
            IDLE: begin
                if (start) begin
                    base_n    = base_addr & ~ADDR_W'(3);
                    dst_n     = dst_addr & ~ADDR_W'(3);
                    cnt_n     = count;
                    idx_n     = '0;
                    max_val_n = '0;
                    max_idx_n = '0;
                    busy_n    = 1'b1;
                    empty_n   = (count == '0);
                    // An empty scan passes through WRITE with the strobe held low so
                    // done lands one cycle later, matching the non-empty timing shape.
                    if (count != '0) begin
                        state_n = READ;
                        addr_n  = base_addr & ~ADDR_W'(3);
                    end else begin
                        state_n = WRITE;
                        addr_n  = '0;
                    end
                end
            end

            READ: begin
                if (take) begin
                    max_val_n = readData;
                    max_idx_n = idx;
                end
                if (last) begin
                    state_n      = WRITE;
                    addr_n       = dst_r;
                    mem_write_n  = 1'b1;
                    write_data_n = take ? readData : max_val;
                end else begin
                    idx_n  = idx_inc;
                    addr_n = base_r + ADDR_W'({idx_inc, 2'b00});
                end
            end

            WRITE: begin
                state_n      = DONE;
                addr_n       = '0;
                write_data_n = '0;
                busy_n       = 1'b0;
                done_n       = 1'b1;
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r    <= '0;
            dst_r     <= '0;
            cnt_r     <= '0;
            idx       <= '0;
            addr      <= '0;
            memWrite  <= 1'b0;
            writeData <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            max_val   <= '0;
            max_idx   <= '0;
            empty     <= 1'b0;
        end else begin
            base_r    <= base_n;
            dst_r     <= dst_n;
            cnt_r     <= cnt_n;
            idx       <= idx_n;
            addr      <= addr_n;
            memWrite  <= mem_write_n;
            writeData <= write_data_n;
            busy      <= busy_n;
            done      <= done_n;
            max_val   <= max_val_n;
            max_idx   <= max_idx_n;
            empty     <= empty_n;
        end
    end

endmodule
